// File: rtl/sdram_rom_loader.sv
// sdram_rom_loader: packs download bytes into 16-bit words and writes them over the ROM port toggle handshake
// Ports: dl_* byte stream in with dl_wait backpressure; rom_addr/rom_din/rom_we/rom_req out, rom_req_ack in
// (a request is pending while rom_req != rom_req_ack); rom_size, sticky overflow and a done pulse report status.
// Define ROM_HEADER_SKIP_EN to add hdr_skip, which discards a 512-byte header and rebases later bytes.
module sdram_rom_loader #(
  parameter int ADDR_W = 24,
  parameter logic [7:0] PAD_BYTE = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
`ifdef ROM_HEADER_SKIP_EN
  input  logic              hdr_skip,
`endif
  output logic              dl_wait,
  output logic [ADDR_W-2:0] rom_addr,
  output logic [15:0]       rom_din,
  output logic              rom_we,
  output logic              rom_req,
  input  logic              rom_req_ack,
  output logic [ADDR_W-1:0] rom_size,
  output logic              overflow,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nxt;
  logic act_q, asm_v, lo_v, hi_v, iss_v, iss_sent;
  logic [7:0] lo, hi;
  logic [ADDR_W-2:0] asm_addr;
  logic [ADDR_W-1:0] eff_addr, size_nxt;
  logic drop, pending, rise, strobe, diff, full, accept, move, fresh;
`ifdef ROM_HEADER_SKIP_EN
  logic skip_q;
  assign drop = skip_q && dl_addr < ADDR_W'(512);
  assign eff_addr = skip_q ? dl_addr - ADDR_W'(512) : dl_addr;
`else
  assign drop = 1'b0;
  assign eff_addr = dl_addr;
`endif
  assign pending = rom_req != rom_req_ack;
  assign rise = dl_active && !act_q;
  assign strobe = state == RUN && dl_active && dl_wr && !drop;
  assign diff = eff_addr[ADDR_W-1:1] != asm_addr;
  assign full = lo_v && hi_v;
  // the presented address tells the source in advance whether its next byte would evict the assembly
  assign dl_wait = iss_v && asm_v && (full || diff);
  assign accept = strobe && !dl_wait;
  assign move = asm_v && !iss_v && (full || state == FLUSH || (accept && diff));
  assign fresh = !asm_v || move;
  assign size_nxt = eff_addr + ADDR_W'(1);
  assign done = state == DONE;
  always_ff @(posedge clk) state <= reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = rise ? RUN : IDLE;
      RUN:     state_nxt = dl_active ? RUN : FLUSH;
      FLUSH:   state_nxt = (!asm_v && !iss_v && !pending) ? DONE : FLUSH;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {act_q, asm_v, lo_v, hi_v, iss_v, iss_sent, rom_req, rom_we, overflow} <= '0;
      lo <= '0;
      hi <= '0;
      asm_addr <= '0;
      rom_addr <= '0;
      rom_din <= '0;
      rom_size <= '0;
`ifdef ROM_HEADER_SKIP_EN
      skip_q <= 1'b0;
`endif
    end else begin
      act_q <= dl_active;
      if (state == IDLE && rise) begin
        rom_size <= '0;
        overflow <= 1'b0;
`ifdef ROM_HEADER_SKIP_EN
        skip_q <= hdr_skip;
`endif
      end
      if (strobe && dl_wait) overflow <= 1'b1;
      if (accept && size_nxt > rom_size) rom_size <= size_nxt;
      // the issue slot's word sits directly on rom_addr/rom_din so it stays stable while the request is pending
      if (move) begin
        iss_v <= 1'b1;
        rom_addr <= asm_addr;
        rom_din <= {hi_v ? hi : PAD_BYTE, lo_v ? lo : PAD_BYTE};
      end
      if (accept) begin
        asm_v <= 1'b1;
        asm_addr <= eff_addr[ADDR_W-1:1];
        lo_v <= !eff_addr[0] || (lo_v && !fresh);
        hi_v <= eff_addr[0] || (hi_v && !fresh);
        if (eff_addr[0]) hi <= dl_data;
        else lo <= dl_data;
      end else if (move) begin
        asm_v <= 1'b0;
        lo_v <= 1'b0;
        hi_v <= 1'b0;
      end
      // first idle cycle with a full slot issues; the next idle cycle (ack seen) frees the slot
      if (iss_v && !pending) begin
        rom_req <= iss_sent ? rom_req : !rom_req;
        rom_we <= 1'b1;
        iss_sent <= !iss_sent;
        iss_v <= !iss_sent;
      end
    end
  end
endmodule

// File: tb/tb_sdram_rom_loader.sv
// tb_sdram_rom_loader: directed bench with a byte-packing reference model and a per-cycle write scoreboard
module tb_sdram_rom_loader;
  localparam int AW = 24;
  logic clk = 0, reset = 1, dl_active = 0, dl_wr = 0, rom_req_ack = 0;
  logic [AW-1:0] dl_addr = '0;
  logic [7:0] dl_data = '0;
`ifdef ROM_HEADER_SKIP_EN
  logic hdr_skip = 0;
`endif
  logic dl_wait, rom_we, rom_req, overflow, done;
  logic [AW-2:0] rom_addr;
  logic [15:0] rom_din;
  logic [AW-1:0] rom_size;
  int checks = 0, errors = 0, ack_delay = 3, ack_cnt = 0, done_cnt = 0;
  logic [38:0] exp_q[$];
  logic [38:0] obs[$];
  logic [38:0] e_w;
  logic last_req = 0, prev_pend = 0;
  logic m_v = 0, m_lov = 0, m_hiv = 0, m_skip = 0;
  logic [AW-2:0] m_word = '0;
  logic [7:0] m_lo = '0, m_hi = '0;
  logic [AW-1:0] m_size = '0;

  always #5 clk = ~clk;

  sdram_rom_loader dut (
    .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
`ifdef ROM_HEADER_SKIP_EN
    .hdr_skip(hdr_skip),
`endif
    .dl_wait(dl_wait), .rom_addr(rom_addr), .rom_din(rom_din), .rom_we(rom_we), .rom_req(rom_req),
    .rom_req_ack(rom_req_ack), .rom_size(rom_size), .overflow(overflow), .done(done)
  );

  always @(posedge clk) begin
    if (reset) begin
      rom_req_ack <= 0;
      ack_cnt <= 0;
    end else if (rom_req != rom_req_ack) begin
      if (ack_cnt >= ack_delay - 1) begin
        rom_req_ack <= rom_req;
        ack_cnt <= 0;
      end else ack_cnt <= ack_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      last_req = 0;
      prev_pend = 0;
    end else begin
      if (rom_req != last_req) begin
        check("one_outstanding", 64'(prev_pend), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h din %0h, want no write", rom_addr, rom_din);
        end else begin
          e_w = exp_q.pop_front();
          check("write", 64'({rom_addr, rom_din}), 64'(e_w));
        end
        check("rom_we", 64'(rom_we), 1);
        obs.push_back({rom_addr, rom_din});
        last_req = rom_req;
      end
      if (done) begin
        done_cnt++;
        check("done_size", 64'(rom_size), 64'(m_size));
        check("done_drained", 64'(exp_q.size()), 0);
        check("done_no_pending", 64'(rom_req ^ rom_req_ack), 0);
      end
      prev_pend = rom_req != rom_req_ack;
    end
  end

  task automatic m_push();
    exp_q.push_back({m_word, m_hiv ? m_hi : 8'hFF, m_lov ? m_lo : 8'hFF});
    m_v = 0;
    m_lov = 0;
    m_hiv = 0;
  endtask

  task automatic m_byte(input logic [AW-1:0] a, input logic [7:0] d);
    logic [AW-1:0] ea;
    if (m_skip && a < 512) return;
    ea = m_skip ? a - AW'(512) : a;
    if (m_v && ea[AW-1:1] != m_word) m_push();
    m_v = 1;
    m_word = ea[AW-1:1];
    if (ea[0]) begin m_hi = d; m_hiv = 1; end
    else begin m_lo = d; m_lov = 1; end
    if (m_lov && m_hiv) m_push();
    if (ea + AW'(1) > m_size) m_size = ea + AW'(1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dl(input logic skip);
    m_v = 0; m_lov = 0; m_hiv = 0; m_size = '0; m_skip = skip;
`ifdef ROM_HEADER_SKIP_EN
    hdr_skip = skip;
`endif
    dl_active = 1;
    tick();
    tick();
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [7:0] d);
    int n = 0;
    dl_addr = a;
    dl_data = d;
    #1;
    while (dl_wait && n < 200) begin tick(); n++; end
    if (dl_wait) begin
      checks++;
      errors++;
      $display("FAIL send_wait: dl_wait still 1 at addr %0h, want 0", a);
    end
    dl_wr = 1;
    tick();
    dl_wr = 0;
    m_byte(a, d);
  endtask

  task automatic finish_dl();
    int n = 0;
    int d0 = done_cnt;
    dl_active = 0;
    if (m_v) m_push();
    while (done_cnt == d0 && n < 300) begin tick(); n++; end
    check("done_seen", 64'(done_cnt), 64'(d0 + 1));
    repeat (3) tick();
    check("done_once", 64'(done_cnt), 64'(d0 + 1));
  endtask

  initial begin
    int base, n;
    logic r;
    repeat (3) tick();
    check("rst_req", 64'(rom_req), 0);
    check("rst_we", 64'(rom_we), 0);
    check("rst_addr", 64'(rom_addr), 0);
    check("rst_din", 64'(rom_din), 0);
    check("rst_size", 64'(rom_size), 0);
    check("rst_wait", 64'(dl_wait), 0);
    check("rst_ovf", 64'(overflow), 0);
    check("rst_done", 64'(done), 0);
    reset = 0;
    tick();
    // aligned stream with 2-cycle issue latency
    base = obs.size();
    start_dl(0);
    send(0, 8'h11);
    send(1, 8'h22);
    r = rom_req;
    tick();
    check("lat_early", 64'(rom_req), 64'(r));
    tick();
    check("lat_toggle", 64'(rom_req), 64'(!r));
    send(2, 8'h33);
    send(3, 8'h44);
    finish_dl();
    check("t1_nwr", 64'(obs.size() - base), 2);
    check("t1_w0", 64'(obs[base]), 64'({23'd0, 16'h2211}));
    check("t1_w1", 64'(obs[base+1]), 64'({23'd1, 16'h4433}));
    check("t1_size", 64'(rom_size), 4);
    // odd length end
    base = obs.size();
    start_dl(0);
    for (int i = 0; i < 3; i++) send(AW'(i), 8'(8'h11 * (i + 1)));
    finish_dl();
    check("t2_nwr", 64'(obs.size() - base), 2);
    check("t2_w1", 64'(obs[base+1]), 64'({23'd1, 16'hFF33}));
    check("t2_size", 64'(rom_size), 3);
    // address jump
    base = obs.size();
    start_dl(0);
    send(AW'('h10), 8'hAA);
    send(AW'('h21), 8'hBB);
    finish_dl();
    check("t3_w0", 64'(obs[base]), 64'({23'h08, 16'hFFAA}));
    check("t3_w1", 64'(obs[base+1]), 64'({23'h10, 16'hBBFF}));
    check("t3_size", 64'(rom_size), 'h22);
    // backpressure and overflow
    base = obs.size();
    ack_delay = 20;
    start_dl(0);
    for (int i = 0; i < 4; i++) send(AW'(i), 8'(i + 1));
    check("bp_ovf0", 64'(overflow), 0);
    check("bp_wait", 64'(dl_wait), 1);
    dl_addr = 4;
    dl_data = 8'h55;
    dl_wr = 1;
    tick();
    dl_wr = 0;
    check("bp_ovf", 64'(overflow), 1);
    check("bp_wait_hold", 64'(dl_wait), 1);
    send(4, 8'h05);
    send(5, 8'h06);
    finish_dl();
    check("t4_nwr", 64'(obs.size() - base), 3);
    check("t4_w2", 64'(obs[base+2]), 64'({23'd2, 16'h0605}));
    check("t4_size", 64'(rom_size), 6);
    check("t4_ovf_sticky", 64'(overflow), 1);
    // reset with a request in flight
    base = obs.size();
    start_dl(0);
    check("ovf_clear", 64'(overflow), 0);
    for (int i = 0; i < 4; i++) send(AW'(i), 8'(8'h70 + i));
    n = 0;
    while (obs.size() < base + 2 && n < 200) begin tick(); n++; end
    check("t5_issued", 64'(obs.size() - base), 2);
    check("t5_pre_req", 64'(rom_req), 1);
    check("t5_pre_pend", 64'(rom_req ^ rom_req_ack), 1);
    check("t5_pre_size", 64'(rom_size), 4);
    n = done_cnt;
    reset = 1;
    exp_q.delete();
    tick();
    check("t5_req", 64'(rom_req), 0);
    check("t5_wait", 64'(dl_wait), 0);
    check("t5_size", 64'(rom_size), 0);
    check("t5_done", 64'(done), 0);
    reset = 0;
    dl_active = 0;
    repeat (6) tick();
    check("t5_no_done", 64'(done_cnt), 64'(n));
    check("t5_req_idle", 64'(rom_req), 0);
`ifdef ROM_HEADER_SKIP_EN
    base = obs.size();
    ack_delay = 1;
    start_dl(1);
    for (int i = 0; i < 516; i++) send(AW'(i), 8'(i));
    finish_dl();
    check("hs_nwr", 64'(obs.size() - base), 2);
    check("hs_w0", 64'(obs[base]), 64'({23'd0, 16'h0100}));
    check("hs_w1", 64'(obs[base+1]), 64'({23'd1, 16'h0302}));
    check("hs_size", 64'(rom_size), 4);
    check("hs_ovf", 64'(overflow), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end
endmodule
